// File: rtl/addr_xlat_initiator.sv
// Address-translation initiator: one request in flight, issued to the translator, answered downstream.
// Define XLAT_TIMEOUT_EN to build the WAIT-state watchdog that returns an error response.
module addr_xlat_initiator #(
    parameter int AddrSize      = 32,
    parameter int TransAddrSize = 24,
    parameter int TimeoutCycles = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    input  logic [AddrSize-1:0]      req_addr_i,
    output logic                     req_ready_o,
    output logic [AddrSize-1:0]      xl_addr_o,
    input  logic [TransAddrSize-1:0] xl_taddr_i,
    input  logic                     xl_rdy_i,
    output logic                     rsp_valid_o,
    output logic [TransAddrSize-1:0] rsp_taddr_o,
    output logic                     rsp_err_o,
    input  logic                     rsp_ready_i
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    if (TimeoutCycles < 2) begin : g_bad_timeout
        $error("TimeoutCycles must be at least 2");
    end

    state_t                   state_reg;
    logic [AddrSize-1:0]      xl_addr_reg;
    logic [TransAddrSize-1:0] rsp_taddr_reg;

`ifdef XLAT_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] wdog_cnt_reg;
    logic            rsp_err_reg;

    assign rsp_err_o = rsp_err_reg;
`else
    assign rsp_err_o = 1'b0;
`endif

    // Handshake flags come straight from state so nothing upstream sees a comb path.
    assign req_ready_o = (state_reg == IDLE);
    assign rsp_valid_o = (state_reg == RESP);
    assign xl_addr_o   = xl_addr_reg;
    assign rsp_taddr_o = rsp_taddr_reg;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg     <= IDLE;
            xl_addr_reg   <= '0;
            rsp_taddr_reg <= '0;
`ifdef XLAT_TIMEOUT_EN
            wdog_cnt_reg  <= '0;
            rsp_err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid_i) begin
                        xl_addr_reg <= req_addr_i;
                        state_reg   <= ISSUE;
                    end
                end
                // Ready is not looked at here: it may still describe the previous address.
                ISSUE: begin
`ifdef XLAT_TIMEOUT_EN
                    wdog_cnt_reg <= '0;
`endif
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (xl_rdy_i) begin
                        rsp_taddr_reg <= xl_taddr_i;
`ifdef XLAT_TIMEOUT_EN
                        rsp_err_reg   <= 1'b0;
`endif
                        state_reg     <= RESP;
                    end
`ifdef XLAT_TIMEOUT_EN
                    else if (wdog_cnt_reg == CntLast) begin
                        rsp_taddr_reg <= '0;
                        rsp_err_reg   <= 1'b1;
                        state_reg     <= RESP;
                    end else begin
                        wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addr_xlat_initiator.sv
// Directed bench for addr_xlat_initiator: transaction scoreboard plus literal latency/reset checks.
module tb_addr_xlat_initiator;

    localparam int AW = 32;
    localparam int TW = 24;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          req_valid = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic          req_ready_o;
    logic [AW-1:0] xl_addr_o;
    logic [TW-1:0] xl_taddr_i;
    logic          xl_rdy_i;
    logic          rsp_valid_o;
    logic [TW-1:0] rsp_taddr_o;
    logic          rsp_err_o;
    logic          rsp_ready = 1'b1;

    // Translator stimulus: either hand-driven or an automatic 2-cycle-latency model.
    logic          auto_xl = 1'b0;
    logic          rdy_man = 1'b0;
    logic [TW-1:0] taddr_man = '0;
    logic          auto_rdy = 1'b0;
    logic [TW-1:0] auto_taddr = '0;
    logic [AW-1:0] auto_seen = '1;
    int            auto_cnt = 0;

    assign xl_rdy_i   = auto_xl ? auto_rdy : rdy_man;
    assign xl_taddr_i = auto_xl ? auto_taddr : taddr_man;

    int n_cmp = 0;
    int n_bad = 0;
    int n_rsp = 0;

    // Scoreboard of expected responses {err, taddr}, in order.
    logic [TW:0]   exp_q[$];
    logic          m_busy = 1'b0;
    logic [AW-1:0] m_xl_addr = '0;
    logic          m_hold = 1'b0;
    logic [TW-1:0] m_taddr = '0;
    logic          m_err = 1'b0;

    addr_xlat_initiator #(
        .AddrSize     (AW),
        .TransAddrSize(TW),
        .TimeoutCycles(TO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req_valid_i(req_valid),
        .req_addr_i (req_addr),
        .req_ready_o(req_ready_o),
        .xl_addr_o  (xl_addr_o),
        .xl_taddr_i (xl_taddr_i),
        .xl_rdy_i   (xl_rdy_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_taddr_o(rsp_taddr_o),
        .rsp_err_o  (rsp_err_o),
        .rsp_ready_i(rsp_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [TW-1:0] xlate(input logic [AW-1:0] a);
        return a[TW-1:0] ^ 24'hC0_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and returns one step after the accepting edge (ISSUE cycle).
    task automatic do_req(input logic [AW-1:0] a);
        int guard = 0;
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        while (!req_ready_o && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready_o) check("req_accept_timeout", 32'(req_ready_o), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (xl_addr_o != auto_seen) begin
            auto_seen = xl_addr_o;
            auto_cnt  = 0;
        end else if (auto_cnt < 255) begin
            auto_cnt++;
        end
        auto_rdy   = (auto_cnt >= 2);
        auto_taddr = auto_rdy ? xlate(auto_seen) : 24'h0;
    end

    // Transaction-level model and per-cycle compare.
    always @(negedge clk) begin
        if (!rst_i) begin
            m_busy    = 1'b0;
            m_xl_addr = '0;
            m_hold    = 1'b0;
            exp_q.delete();
        end else begin
            check("xl_addr", xl_addr_o, m_xl_addr);
            check("req_ready", 32'(req_ready_o), 32'(!m_busy));
            check("rsp_without_req", 32'(rsp_valid_o && !m_busy), 32'd0);
            if (m_hold) begin
                check("hold_valid", 32'(rsp_valid_o), 32'd1);
                check("hold_taddr", 32'(rsp_taddr_o), 32'(m_taddr));
                check("hold_err", 32'(rsp_err_o), 32'(m_err));
            end
            m_hold  = rsp_valid_o && !rsp_ready;
            m_taddr = rsp_taddr_o;
            m_err   = rsp_err_o;
            if (rsp_valid_o && rsp_ready) begin
                n_rsp++;
                $display("RSP taddr=0x%06h err=%0d", rsp_taddr_o, rsp_err_o);
                check("rsp_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    logic [TW:0] e;
                    e = exp_q.pop_front();
                    check("rsp_taddr", 32'(rsp_taddr_o), 32'(e[TW-1:0]));
                    check("rsp_err", 32'(rsp_err_o), 32'(e[TW]));
                end
                m_busy = 1'b0;
            end
            if (req_valid && req_ready_o) begin
                $display("REQ addr=0x%08h", req_addr);
                m_busy    = 1'b1;
                m_xl_addr = req_addr;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int cnt;
        int g;
        int rsp0;

        // Reset held for 100 cycles.
        repeat (100) @(posedge clk);
        #1 rst_i = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready_o), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_xl_addr", xl_addr_o, 32'd0);
        check("rst_rsp_taddr", 32'(rsp_taddr_o), 32'd0);
        check("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        tick();

        // Single translation, ready in the first WAIT cycle.
        exp_q.push_back({1'b0, 24'h00_5A5A});
        do_req(32'h0000_1234);
        check("single_xl_addr_c1", xl_addr_o, 32'h0000_1234);
        check("single_ready_c1", 32'(req_ready_o), 32'd0);
        tick();
        check("single_valid_c2", 32'(rsp_valid_o), 32'd0);
        taddr_man = 24'h00_5A5A;
        rdy_man   = 1'b1;
        tick();
        check("single_valid_c3", 32'(rsp_valid_o), 32'd1);
        check("single_taddr_c3", 32'(rsp_taddr_o), 32'h5A5A);
        check("single_err_c3", 32'(rsp_err_o), 32'd0);
        rdy_man = 1'b0;
        tick();
        check("single_idle", 32'(req_ready_o), 32'd1);

        // Stale ready during ISSUE, then 5 cycles of backpressure.
        rdy_man   = 1'b1;
        taddr_man = 24'h00_00CD;
        rsp_ready = 1'b0;
        exp_q.push_back({1'b0, 24'h00_00AB});
        do_req(32'h0000_4000);
        tick();
        taddr_man = 24'h00_00AB;
        tick();
        taddr_man = 24'h00_00EF;
        for (int i = 0; i < 5; i++) begin
            check("stale_valid", 32'(rsp_valid_o), 32'd1);
            check("stale_taddr", 32'(rsp_taddr_o), 32'h0000_00AB);
            check("stale_req_ready", 32'(req_ready_o), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("stale_back_idle", 32'(req_ready_o), 32'd1);
        check("stale_valid_drop", 32'(rsp_valid_o), 32'd0);
        rdy_man = 1'b0;

`ifdef XLAT_TIMEOUT_EN
        // Translator never answers: error after 16 WAIT edges.
        exp_q.push_back({1'b1, 24'h0});
        do_req(32'h0000_0077);
        tick();
        repeat (TO - 1) tick();
        check("to_valid_early", 32'(rsp_valid_o), 32'd0);
        tick();
        check("to_valid", 32'(rsp_valid_o), 32'd1);
        check("to_err", 32'(rsp_err_o), 32'd1);
        check("to_taddr", 32'(rsp_taddr_o), 32'd0);
        tick();

        // Ready on the final timeout cycle wins.
        exp_q.push_back({1'b0, 24'h12_3456});
        do_req(32'h0000_0066);
        tick();
        repeat (TO - 1) tick();
        rdy_man   = 1'b1;
        taddr_man = 24'h12_3456;
        tick();
        check("to_edge_valid", 32'(rsp_valid_o), 32'd1);
        check("to_edge_err", 32'(rsp_err_o), 32'd0);
        check("to_edge_taddr", 32'(rsp_taddr_o), 32'h0012_3456);
        rdy_man = 1'b0;
        tick();
`else
        // Without the watchdog a silent translator is waited on indefinitely.
        exp_q.push_back({1'b0, 24'h00_0888});
        do_req(32'h0000_0088);
        cnt = 0;
        repeat (40) begin
            tick();
            if (rsp_valid_o) cnt++;
        end
        check("nowd_no_rsp", 32'(cnt), 32'd0);
        check("nowd_err_tied", 32'(rsp_err_o), 32'd0);
        rdy_man   = 1'b1;
        taddr_man = 24'h00_0888;
        tick();
        check("nowd_valid", 32'(rsp_valid_o), 32'd1);
        check("nowd_taddr", 32'(rsp_taddr_o), 32'h0000_0888);
        rdy_man = 1'b0;
        tick();
`endif

        // Back-to-back requests through a 2-cycle-latency translator.
        auto_xl = 1'b1;
        rsp0    = n_rsp;
        exp_q.push_back({1'b0, 24'hC0_0010});
        do_req(32'h0000_0010);
        exp_q.push_back({1'b0, 24'hC0_0020});
        do_req(32'h0000_0020);
        exp_q.push_back({1'b0, 24'hC0_0030});
        do_req(32'h0000_0030);
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            tick();
            g++;
        end
        check("b2b_drained", 32'(exp_q.size()), 32'd0);
        check("b2b_count", 32'(n_rsp - rsp0), 32'd3);
        auto_xl = 1'b0;
        tick();

        // Reset during WAIT drops the request.
        rdy_man = 1'b0;
        rsp0    = n_rsp;
        do_req(32'h0000_0099);
        tick();
        tick();
        #2 rst_i = 1'b0;
        #1;
        check("rstw_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rstw_req_ready", 32'(req_ready_o), 32'd1);
        check("rstw_xl_addr", xl_addr_o, 32'd0);
        tick();
        tick();
        rst_i     = 1'b1;
        rdy_man   = 1'b1;
        taddr_man = 24'h00_0055;
        cnt = 0;
        repeat (10) begin
            tick();
            if (rsp_valid_o) cnt++;
        end
        check("rstw_no_rsp", 32'(cnt), 32'd0);
        check("rstw_no_handshake", 32'(n_rsp - rsp0), 32'd0);

        // Reset while a response is being held drops it at once.
        rsp_ready = 1'b0;
        taddr_man = 24'h00_0077;
        exp_q.push_back({1'b0, 24'h00_0077});
        do_req(32'h0000_00AA);
        tick();
        tick();
        check("rstr_valid_before", 32'(rsp_valid_o), 32'd1);
        #2 rst_i = 1'b0;
        #1;
        check("rstr_valid_after", 32'(rsp_valid_o), 32'd0);
        check("rstr_taddr_after", 32'(rsp_taddr_o), 32'd0);
        tick();
        rst_i     = 1'b1;
        rsp_ready = 1'b1;
        rdy_man   = 1'b0;
        repeat (3) tick();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/addr_xlat_initiator.md
# addr_xlat_initiator

Initiator for the address-translation interface: accepts untranslated addresses from an upstream requester over a valid/ready handshake and drives them to the translator's `addr` input. It waits for the translator's ready, captures the translated address, and returns it downstream over a second valid/ready handshake. An optional watchdog reports a translator that never answers. The block sits between the core-side address source and the translation unit.

## Interface
Parameters:
- `AddrSize`, default 32 (`ADDR_SIZE`): width of the untranslated address.
- `TransAddrSize`, default 24 (`T_ADDR_SIZE`): width of the translated address.
- `TimeoutCycles`, default 16: WAIT cycles before a timeout error, ≥2; used only with the timeout macro.

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  1  upstream request valid.
- `req_addr_i`  in  AddrSize  upstream untranslated address.
- `req_ready_o`  out  1  block can accept a request.
- `xl_addr_o`  out  AddrSize  address driven to the translator's `addr_i`.
- `xl_taddr_i`  in  TransAddrSize  translator's `taddr_o`.
- `xl_rdy_i`  in  1  translator's `rdy_o`.
- `rsp_valid_o`  out  1  response valid.
- `rsp_taddr_o`  out  TransAddrSize  captured translated address.
- `rsp_err_o`  out  1  response is a timeout error.
- `rsp_ready_i`  in  1  downstream accepts the response.

## Operation
FSM states are IDLE, ISSUE, WAIT and RESP. Only one request is in flight at a time.
- **IDLE:** `req_ready_o`=1.
  - If `req_valid_i`=1 at the edge: register `req_addr_i` into `xl_addr_o` and go to ISSUE.
- **ISSUE:** lasts one cycle so the translator sees the new address.
  - `xl_rdy_i` is ignored, because it may be stale from the previous address.
  - Clear the watchdog counter and go to WAIT.
- **WAIT:**
  - If `xl_rdy_i`=1 at the edge: capture `xl_taddr_i` into `rsp_taddr_o`, set `rsp_err_o`=0, go to RESP.
  - With the timeout macro: the counter increments each WAIT cycle without ready. When it reaches `TimeoutCycles`-1 and ready is still low, set `rsp_taddr_o`=0, set `rsp_err_o`=1, go to RESP.
  - If ready and the final timeout cycle coincide, ready wins and no error is reported.
- **RESP:**
  - `rsp_valid_o`=1. `rsp_taddr_o` and `rsp_err_o` hold stable until accepted.
  - On `rsp_ready_i`=1 at the edge, go to IDLE.
  - `req_ready_o`=0, so no request is accepted in the same cycle.
- `xl_addr_o` keeps its last value outside ISSUE and WAIT. It changes only on request acceptance.
- `req_ready_o` and `rsp_valid_o` are decoded from state, with no combinational path from inputs.
- Upstream must hold `req_addr_i` stable while `req_valid_i`=1 and `req_ready_o`=0.

## Timing
- **Reset values:** state=IDLE, `req_ready_o`=1, `xl_addr_o`=0, `rsp_valid_o`=0, `rsp_taddr_o`=0, `rsp_err_o`=0, watchdog counter=0.
- **Reset mid-operation:** asserting `rst_i` low clears everything immediately without waiting for a clock edge. Any in-flight request is dropped and no response is produced.
- **Latency:**
  - Cycle 0: request accepted at the edge.
  - Cycle 1: ISSUE.
  - Cycle 2: first WAIT sample.
  - If `xl_rdy_i` is high in cycle 2, `rsp_valid_o` rises after the cycle-2 edge. Minimum request-to-response is 3 edges.
- **Throughput:** at best one request per 4 cycles (IDLE, ISSUE, WAIT, RESP). Downstream backpressure extends RESP indefinitely.
- **Timeout:** the error response appears `TimeoutCycles` WAIT edges after entering WAIT.

## Configuration
Macro `XLAT_TIMEOUT_EN`.
- **Defined:**
  - The watchdog counter is present, sized to `TimeoutCycles`.
  - The WAIT-state timeout exit is active.
  - `rsp_err_o` reports timeouts.
- **Undefined:**
  - No counter is built and WAIT waits indefinitely for `xl_rdy_i`.
  - `rsp_err_o` is tied to 0.
  - `TimeoutCycles` is unused.

## Test plan
- **Reset:** hold `rst_i`=0 for 100 cycles, release → `req_ready_o`=1, `rsp_valid_o`=0, `xl_addr_o`=0, `rsp_taddr_o`=0, `rsp_err_o`=0.
- **Single translation:** `req_addr_i`=0x0000_1234; translator model returns `taddr`=0x00_5A5A with rdy 1 cycle after ISSUE → `xl_addr_o`=0x1234 from cycle 1, `rsp_valid_o`=1 at cycle 3 with `rsp_taddr_o`=0x5A5A, `rsp_err_o`=0.
- **Stale ready and backpressure:**
  - Stimulus: hold `xl_rdy_i`=1 constantly; `xl_taddr_i` changes to 0x00_00AB only in the first WAIT cycle; keep `rsp_ready_i`=0 for 5 cycles.
  - Response: captured value is 0x00AB, not the ISSUE-cycle value; the response stays stable for 5 cycles; `req_ready_o`=0 throughout; IDLE is entered after `rsp_ready_i`=1.
- **Timeout (macro defined, `TimeoutCycles`=16):** `xl_rdy_i` held 0 → `rsp_valid_o`=1 with `rsp_err_o`=1 and `rsp_taddr_o`=0, 16 WAIT edges after entering WAIT. A variant raising rdy exactly on the 16th cycle → `rsp_err_o`=0.
- **Back-to-back requests:** addresses 0x10, 0x20, 0x30 queued upstream, translator with 2-cycle latency, `rsp_ready_i`=1 → three responses in order with matching `taddr`, no drops or duplicates.
- **Reset mid-WAIT:** drop `rst_i` during WAIT → `rsp_valid_o`=0 immediately, state IDLE; no response is produced after release.
